mult_arbiter: RTL and testbench

Round-robin arbiter and two-stage pipeline sequencer that shares the single 16-bit combinational `Mult` among the equalizer's band filters. Each band presents an operand pair with a request. The arbiter grants one band per cycle and drives the registered operands into `Mult`. It then registers `Mult`'s `Y` and returns it with a one-hot completion strobe to the band that issued it. It sits between the band-filter controllers and the one `Mult` instance in the equalizer datapath.

---
 rtl/mult_arbiter_if.sv | 27 ++
 rtl/mult_arbiter.sv | 109 ++++++++++
 tb/tb_mult_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_arbiter_if.sv
// Bus between the band-filter controllers, the multiplier arbiter and the shared Mult instance.
// The master modport belongs to the requester/Mult side and the slave modport to the arbiter.
interface mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       mult_a;
  logic [WIDTH-1:0]       mult_b;
  logic [WIDTH-1:0]       mult_y;
  logic [WIDTH-1:0]       y_out;
  logic [N_REQ-1:0]       done;
  logic [15:0]            op_count;

  modport slave (
    input  req, a_in, b_in, mult_y,
    output gnt, mult_a, mult_b, y_out, done, op_count
  );

  modport master (
    output req, a_in, b_in, mult_y,
    input  gnt, mult_a, mult_b, y_out, done, op_count
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter with a two-stage pipeline that time-shares one combinational multiplier.
// Stage 0 picks a requester and registers its operands; stage 1 registers Mult.Y and tags it with the owner.
module mult_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  mult_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = bus.a_in[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = bus.b_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0] s1_owner_q, s1_owner_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [WIDTH-1:0] mult_a_q, mult_a_d;
  logic [WIDTH-1:0] mult_b_q, mult_b_d;
  logic [WIDTH-1:0] y_out_q, y_out_d;
  logic [15:0]      op_count_q, op_count_d;

  // Search starts one past the last winner and wraps, so the last winner is checked last.
  always_comb begin : arbitrate
    logic [IDX_W-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = last_q;
    cand_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_idx = IDX_W'((int'(last_q) + k) % N_REQ);
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin : next_state
    last_d     = last_q;
    s1_valid_d = win_found;
    s1_owner_d = s1_owner_q;
    gnt_d      = '0;
    mult_a_d   = mult_a_q;
    mult_b_d   = mult_b_q;
    done_d     = '0;
    y_out_d    = y_out_q;
    op_count_d = op_count_q;

    if (win_found) begin
      last_d           = win_idx;
      s1_owner_d       = win_idx;
      gnt_d[win_idx]   = 1'b1;
      mult_a_d         = a_arr[win_idx];
      mult_b_d         = b_arr[win_idx];
    end

    // Mult.Y is settled from the operands registered on the previous edge.
    if (s1_valid_q) begin
      y_out_d              = bus.mult_y;
      done_d[s1_owner_q]   = 1'b1;
      op_count_d           = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= LAST_RST;
      s1_valid_q <= 1'b0;
      s1_owner_q <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      mult_a_q   <= '0;
      mult_b_q   <= '0;
      y_out_q    <= '0;
      op_count_q <= '0;
    end else begin
      last_q     <= last_d;
      s1_valid_q <= s1_valid_d;
      s1_owner_q <= s1_owner_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      mult_a_q   <= mult_a_d;
      mult_b_q   <= mult_b_d;
      y_out_q    <= y_out_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.mult_a   = mult_a_q;
  assign bus.mult_b   = mult_b_q;
  assign bus.y_out    = y_out_q;
  assign bus.op_count = op_count_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mult_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
  mult_arbiter #(.N_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Shared multiplier: XOR stub for tag checks, low half of the full product otherwise.
  logic use_real = 1'b0;
  logic [2*W-1:0] prod;
  always_comb begin
    prod       = {{W{1'b0}}, bus.mult_a} * {{W{1'b0}}, bus.mult_b};
    bus.mult_y = use_real ? prod[W-1:0] : (bus.mult_a ^ bus.mult_b);
  end

  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.a_in[i*W +: W] = op_a[i];
      bus.b_in[i*W +: W] = op_b[i];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each cycle, a transaction granted in the previous cycle completes,
  // and the first requester after the last winner (cyclically) is granted.
  int           m_last;
  logic         m_pend;
  int           m_own;
  logic [W-1:0] m_pa, m_pb;
  logic [N-1:0] e_gnt, e_done;
  logic [W-1:0] e_ma, e_mb, e_y;
  logic [15:0]  e_cnt;

  function automatic logic [W-1:0] mult_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic real_m);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return real_m ? p[W-1:0] : (a ^ b);
  endfunction

  task automatic model_step();
    int c;
    if (rst) begin
      m_last = N - 1;
      m_pend = 1'b0;
      m_own  = 0;
      e_gnt  = '0;
      e_done = '0;
      e_ma   = '0;
      e_mb   = '0;
      e_y    = '0;
      e_cnt  = '0;
    end else begin
      e_done = '0;
      if (m_pend) begin
        e_y           = mult_ref(m_pa, m_pb, use_real);
        e_done[m_own] = 1'b1;
        e_cnt         = e_cnt + 16'd1;
      end
      m_pend = 1'b0;
      e_gnt  = '0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!m_pend && bus.req[c]) begin
          m_pend   = 1'b1;
          m_own    = c;
          m_pa     = op_a[c];
          m_pb     = op_b[c];
          e_gnt[c] = 1'b1;
          e_ma     = op_a[c];
          e_mb     = op_b[c];
        end
      end
      if (m_pend) m_last = m_own;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", 32'(bus.gnt), 32'(e_gnt));
      check("done", 32'(bus.done), 32'(e_done));
      check("mult_a", 32'(bus.mult_a), 32'(e_ma));
      check("mult_b", 32'(bus.mult_b), 32'(e_mb));
      check("y_out", 32'(bus.y_out), 32'(e_y));
      check("op_count", 32'(bus.op_count), 32'(e_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Protocol-respecting random requesters: hold until granted, then optionally present a new pair.
  task automatic drive_random(input int cycles);
    logic [N-1:0] r;
    for (int c = 0; c < cycles; c++) begin
      r = bus.req;
      for (int i = 0; i < N; i++) begin
        if (!r[i] || e_gnt[i]) begin
          r[i]    = ($urandom_range(0, 3) != 0);
          op_a[i] = W'($urandom);
          op_b[i] = W'($urandom);
        end
      end
      bus.req = r;
      tick();
    end
  endtask

  initial begin
    bus.req = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_y", 32'(bus.y_out), 32'h0);
    check("rst_cnt", 32'(bus.op_count), 32'h0);
    check("rst_ma", 32'(bus.mult_a), 32'h0);

    // Single request through the XOR stub
    op_a[0] = 16'h1234;
    op_b[0] = 16'h00FF;
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    check("single_gnt", 32'(bus.gnt), 32'h1);
    check("single_ma", 32'(bus.mult_a), 32'h1234);
    check("single_mb", 32'(bus.mult_b), 32'h00FF);
    tick();
    check("single_done", 32'(bus.done), 32'h1);
    check("single_y", 32'(bus.y_out), 32'h12CB);
    check("single_cnt", 32'(bus.op_count), 32'h1);
    tick();

    // All four requesting continuously
    do_reset();
    for (int i = 0; i < N; i++) begin
      op_a[i] = 16'h1111 * 16'(i + 1);
      op_b[i] = 16'h0F0F + 16'(i);
    end
    bus.req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_gnt", 32'(bus.gnt), 32'(1 << (k % 4)));
      if (k >= 1) begin
        check("rr_done", 32'(bus.done), 32'(1 << ((k - 1) % 4)));
        check("rr_y", 32'(bus.y_out), 32'(op_a[(k - 1) % 4] ^ op_b[(k - 1) % 4]));
      end
    end
    bus.req = '0;
    tick();
    tick();

    // Round-robin resume after requester 2
    do_reset();
    bus.req = 4'b0100;
    tick();
    check("resume_g2", 32'(bus.gnt), 32'b0100);
    bus.req = 4'b1101;
    tick();
    check("resume_g3", 32'(bus.gnt), 32'b1000);
    tick();
    check("resume_g0", 32'(bus.gnt), 32'b0001);
    tick();
    check("resume_g2b", 32'(bus.gnt), 32'b0100);
    bus.req = 4'b0101;
    tick();
    check("resume_g0b", 32'(bus.gnt), 32'b0001);
    bus.req = '0;
    tick();
    tick();

    // Reset while requester 1 holds the grant
    do_reset();
    bus.req = 4'b0011;
    tick();
    check("midrst_g0", 32'(bus.gnt), 32'b0001);
    bus.req = 4'b0010;
    tick();
    check("midrst_g1", 32'(bus.gnt), 32'b0010);
    rst = 1'b1;
    bus.req = '0;
    tick();
    check("midrst_done", 32'(bus.done), 32'h0);
    check("midrst_y", 32'(bus.y_out), 32'h0);
    check("midrst_cnt", 32'(bus.op_count), 32'h0);
    rst = 1'b0;
    bus.req = 4'b1001;
    tick();
    check("midrst_after_g0", 32'(bus.gnt), 32'b0001);
    check("midrst_no_done", 32'(bus.done), 32'h0);
    bus.req = 4'b1000;
    tick();
    check("midrst_after_g3", 32'(bus.gnt), 32'b1000);
    bus.req = '0;
    tick();
    tick();

    // Full-product multiplier pass-through, back to back
    use_real = 1'b1;
    do_reset();
    op_a[0] = 16'h8000;
    op_b[0] = 16'h8000;
    op_a[1] = 16'hEFFF;
    op_b[1] = 16'hEFFF;
    bus.req = 4'b0011;
    tick();
    bus.req = 4'b0010;
    tick();
    bus.req = '0;
    check("real_done0", 32'(bus.done), 32'b0001);
    check("real_y0", 32'(bus.y_out), 32'h0000);
    tick();
    check("real_done1", 32'(bus.done), 32'b0010);
    check("real_y1", 32'(bus.y_out), 32'h2001);
    tick();
    use_real = 1'b0;
    tick();

    // Randomized traffic
    do_reset();
    drive_random(1500);
    bus.req = '0;
    tick();
    tick();

    // Completion counter wrap
    do_reset();
    bus.req = 4'hF;
    repeat (65536) tick();
    check("wrap_ffff", 32'(bus.op_count), 32'hFFFF);
    bus.req = '0;
    tick();
    check("wrap_zero", 32'(bus.op_count), 32'h0000);
    check("wrap_done", 32'(bus.done), 32'b1000);
    tick();
    check("wrap_hold", 32'(bus.op_count), 32'h0000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
